max_pool_layer: RTL
===================

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

Interface
REQ-001: Parameter IMG_DIM, default 28, input image side length in pixels; SHALL be even.
REQ-002: Parameter DATA_W, default 16, pixel width, two's-complement signed.
REQ-003: Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004: Port reset  input  1  synchronous, active-high reset.
REQ-005: Port enable  input  1  start/hold request, level-sensitive.
REQ-006: Port img  input  signed [DATA_W-1:0] array [0:IMG_DIM*IMG_DIM-1]  row-major input image; index = row*IMG_DIM+col.
REQ-007: Port pooled_img  output  signed [DATA_W-1:0] array [0:(IMG_DIM/2)**2-1]  row-major pooled result; feeds dense_layer1 pooled_img directly.
REQ-008: Port pool_done  output  1  result complete and valid; drives dense_layer1 enable.

Function
REQ-009: SHALL implement states IDLE, POOL, DONE, with a window counter k from 0 to (IMG_DIM/2)**2-1.
REQ-010: IDLE: if enable=1 at a rising edge, SHALL clear k to 0 and go to POOL; otherwise stay in IDLE.
REQ-011: POOL: each rising edge SHALL write exactly one output, pooled_img[k] = signed max of img[(2r)*IMG_DIM+2c], img[(2r)*IMG_DIM+2c+1], img[(2r+1)*IMG_DIM+2c], img[(2r+1)*IMG_DIM+2c+1], where r = k / (IMG_DIM/2) and c = k mod (IMG_DIM/2).
REQ-012: Comparison SHALL be signed across the full DATA_W range; ties give that same value; no saturation or rescaling.
REQ-013: POOL: after writing the last index ((IMG_DIM/2)**2-1) SHALL go to DONE and assert pool_done in the same edge; k SHALL NOT wrap to 0 inside POOL.
REQ-014: Latency: enable sampled at edge E gives pooled_img[k] updated at edge E+1+k; pool_done high after edge E+196 (default parameters).
REQ-015: enable is ignored while in POOL; deasserting it mid-run SHALL NOT abort or stall the pass.
REQ-016: DONE: pool_done SHALL stay 1 and pooled_img SHALL hold while enable=1; when enable=0 at an edge, SHALL go to IDLE and clear pool_done.
REQ-017: In IDLE and DONE, pooled_img SHALL retain its last written values; a new pass from IDLE overwrites every entry.
REQ-018: img SHALL be held stable by the upstream stage from the enable edge until pool_done; the block SHALL NOT latch img.
REQ-019: pool_done SHALL be registered, never a combinational function of enable.

Reset
REQ-020: reset=1 at a rising edge SHALL force state IDLE, k=0, pool_done=0, and every pooled_img entry to 0, overriding enable.
REQ-021: reset asserted mid-POOL SHALL abort the pass with the same result as REQ-020; no partial-pass residue.
REQ-022: After reset deasserts, the first edge with enable=1 SHALL start a fresh pass per REQ-010.

Verification
REQ-023: Zero image, enable held high from cycle 5 -> pool_done rises exactly 196 cycles after the enable edge; all 196 outputs are 0.
REQ-024: Ramp img[i]=i -> pooled_img[k] = (2r+1)*28+2c+1, e.g. pooled_img[0]=29, pooled_img[195]=783.
REQ-025: Signed check: every pixel -5 except one -1 per window at rotating positions -> all outputs -1. Also one window {-32768, 32767, 0, -1} -> 32767.
REQ-026: Reset at POOL k=50 -> next cycle pool_done=0 and all outputs 0. With enable still high after reset release, a fresh pass completes in 196 cycles.
REQ-027: Handshake: drop enable for 10 cycles mid-POOL -> done still at edge E+196. Then in DONE, drop enable -> pool_done falls next edge and outputs hold. Re-enable -> a second identical pass.
REQ-028: enable held low for 500 cycles after reset -> pool_done stays 0 and all outputs stay 0.

Source files
------------

// File: rtl/max_pool_layer.sv
// -----------------------------------------------------------------------------
// max_pool_layer
//
// Purpose:
//   2x2, stride-2 max pooling over a square, row-major, signed image. The
//   block emits one pooled output per clock. A full pass over the default
//   28x28 image takes 196 cycles after the start edge. The result stays in an
//   output register bank until a new pass or a reset overwrites it.
//
//   Control is a three-state machine:
//     IDLE : waits for enable. The enable edge starts a pass.
//     POOL : writes pooled_img[k] once per cycle, k = 0 .. (IMG_DIM/2)**2-1.
//            enable is ignored here, so a pass always runs to completion.
//     DONE : holds the result and pool_done while enable stays high. The
//            block returns to IDLE on the first edge that samples enable low.
//
//   The window address is kept as a running base pointer (top-left pixel)
//   plus a column counter. This avoids any divide or modulo by IMG_DIM/2.
//   The pointer steps by 2 within a pooled row. At the end of a row it steps
//   by IMG_DIM+2, which skips the second input row of the window pair.
//
// Parameters:
//   IMG_DIM    input image side length in pixels (even)
//   DATA_W     pixel width, two's-complement signed
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high; clears state and the result
//   enable      in   level-sensitive start / hold request
//   img         in   IMG_DIM*IMG_DIM signed pixels, index = row*IMG_DIM+col;
//                    must be held stable by upstream for the whole pass
//   pooled_img  out  (IMG_DIM/2)**2 signed pooled pixels, row-major
//   pool_done   out  registered; high while a complete result is presented
// -----------------------------------------------------------------------------
module max_pool_layer #(
    parameter int IMG_DIM = 28,
    parameter int DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] img        [0:IMG_DIM*IMG_DIM-1],
    output logic signed [DATA_W-1:0] pooled_img [0:(IMG_DIM/2)**2-1],
    output logic                     pool_done
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int HALF  = IMG_DIM / 2;
    localparam int N_IN  = IMG_DIM * IMG_DIM;
    localparam int N_OUT = HALF * HALF;

    localparam int IDX_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int C_W   = (HALF  > 1) ? $clog2(HALF)  : 1;

    localparam logic [K_W-1:0]   K_LAST    = K_W'(N_OUT - 1);
    localparam logic [C_W-1:0]   C_LAST    = C_W'(HALF - 1);
    localparam logic [IDX_W-1:0] COL_STEP  = IDX_W'(2);
    localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(IMG_DIM + 2);
    localparam logic [IDX_W-1:0] ROW_PITCH = IDX_W'(IMG_DIM);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POOL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [K_W-1:0]   k;       // output (window) index being written this cycle
    logic [C_W-1:0]   col;     // pooled column of window k
    logic [IDX_W-1:0] base;    // img index of the top-left pixel of window k

    // -------------------------------------------------------------------------
    // Window fetch and signed maximum
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] idx_tl;
    logic [IDX_W-1:0] idx_tr;
    logic [IDX_W-1:0] idx_bl;
    logic [IDX_W-1:0] idx_br;

    logic signed [DATA_W-1:0] max_top;
    logic signed [DATA_W-1:0] max_bot;
    logic signed [DATA_W-1:0] win_max;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        // Both operands are signed, so '>' is a two's-complement compare.
        // On a tie either operand is the correct result.
        return (a > b) ? a : b;
    endfunction

    assign idx_tl = base;
    assign idx_tr = base + ONE_IDX;
    assign idx_bl = base + ROW_PITCH;
    assign idx_br = base + ROW_PITCH + ONE_IDX;

    assign max_top = smax(img[idx_tl], img[idx_tr]);
    assign max_bot = smax(img[idx_bl], img[idx_br]);
    assign win_max = smax(max_top, max_bot);

    // -------------------------------------------------------------------------
    // Control, address walk and result bank
    // -------------------------------------------------------------------------
    // NOTE: all state here is assigned with <= so that every register samples
    // pre-edge values. Blocking '=' would let base/k updates leak into the same
    // cycle's write address and shift every output by one window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            col       <= '0;
            base      <= '0;
            pool_done <= 1'b0;
            // NOTE: the result bank is a register array, not RAM, and it must
            // read as all-zero after reset. An aborted pass must leave no
            // partial data behind, so every entry is cleared explicitly.
            for (int i = 0; i < N_OUT; i++) begin
                pooled_img[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        k     <= '0;
                        col   <= '0;
                        base  <= '0;
                        state <= POOL;
                    end
                end

                POOL: begin
                    pooled_img[k] <= win_max;
                    if (k == K_LAST) begin
                        // Last window written: finish without wrapping k.
                        state     <= DONE;
                        pool_done <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                        if (col == C_LAST) begin
                            col  <= '0;
                            base <= base + ROW_STEP;
                        end else begin
                            col  <= col + 1'b1;
                            base <= base + COL_STEP;
                        end
                    end
                end

                DONE: begin
                    if (!enable) begin
                        state     <= IDLE;
                        pool_done <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pool_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
